// File: rtl/set_assoc_cache_n_ways_if.sv
// Pipeline request/response and main-RAM fetch/flush handshakes for set_assoc_cache_n_ways.
// master drives requests and RAM responses; slave is the cache.
interface set_assoc_cache_n_ways_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAT_WIDTH = 16
);
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  inval;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  fetch_ack;
    logic                  flush_ack;
    logic [DATA_WIDTH-1:0] douta;
    logic                  hit;
    logic                  busy;
    logic                  fetch;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [STAT_WIDTH-1:0] hit_count;
    logic [STAT_WIDTH-1:0] miss_count;

    modport master (
        output ena, wea, addra, dina, inval, ram_rdata, fetch_ack, flush_ack,
        input  douta, hit, busy, fetch, flush, ram_addr, ram_wdata, hit_count, miss_count
    );

    modport slave (
        input  ena, wea, addra, dina, inval, ram_rdata, fetch_ack, flush_ack,
        output douta, hit, busy, fetch, flush, ram_addr, ram_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/set_assoc_cache_n_ways.sv
// N-way set-associative write-through cache with per-set round-robin replacement,
// invalidate-all and saturating hit/miss counters.
module set_assoc_cache_n_ways #(
    parameter int unsigned WORDS          = 1024,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WAYS           = 2,
    parameter int unsigned WRITE_ALLOCATE = 1,
    parameter int unsigned STAT_WIDTH     = 16
) (
    input logic                     clka,
    input logic                     rsta,
    set_assoc_cache_n_ways_if.slave bus
);
    localparam int unsigned SETS  = WORDS / WAYS;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned MEM_W = $clog2(SETS * WAYS);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      tag_q    [SETS][WAYS];
    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WAY_W-1:0]      ptr_q    [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS*WAYS];

    logic [DATA_WIDTH-1:0] douta_q, douta_d;
    logic                  hit_q, hit_d;
    logic                  busy_q, busy_d;
    logic                  fetch_q, fetch_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [STAT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [STAT_WIDTH-1:0] miss_count_q, miss_count_d;

    logic                  hit_inc, miss_inc;
    logic                  fill_en, wr_hit_en, inval_en;
    logic [DATA_WIDTH-1:0] fill_data;

    // Lookups use the live address in IDLE and the latched miss address while fetching.
    logic [ADDR_WIDTH-1:0] look_addr;
    logic [IDX_W-1:0]      look_idx;
    logic [TAG_W-1:0]      look_tag;
    logic                  hit_any;
    logic                  found_inv;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_way;
    logic [MEM_W-1:0]      hit_slot;
    logic [MEM_W-1:0]      fill_slot;

    assign look_addr = (state_q == FETCH) ? ram_addr_q : bus.addra;
    assign look_idx  = look_addr[IDX_W-1:0];
    assign look_tag  = look_addr[ADDR_WIDTH-1:IDX_W];
    assign hit_slot  = MEM_W'(32'(look_idx) * WAYS + 32'(hit_way));
    assign fill_slot = MEM_W'(32'(look_idx) * WAYS + 32'(victim_way));

    // Tag compare and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit_any    = 1'b0;
        hit_way    = '0;
        found_inv  = 1'b0;
        victim_way = ptr_q[look_idx];
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[look_idx][w] && (tag_q[look_idx][w] == look_tag) && !hit_any) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[look_idx][w] && !found_inv) begin
                found_inv  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        douta_d      = douta_q;
        hit_d        = 1'b0;
        busy_d       = busy_q;
        fetch_d      = fetch_q;
        flush_d      = flush_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        fill_en      = 1'b0;
        fill_data    = bus.dina;
        wr_hit_en    = 1'b0;
        inval_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.inval) begin
                    inval_en = 1'b1;
                end else if (bus.ena) begin
                    if (bus.wea) begin
                        ram_addr_d  = bus.addra;
                        ram_wdata_d = bus.dina;
                        flush_d     = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = FLUSH;
                        if (hit_any) begin
                            wr_hit_en = 1'b1;
                            hit_d     = 1'b1;
                            hit_inc   = 1'b1;
                        end else begin
                            miss_inc = 1'b1;
                            fill_en  = (WRITE_ALLOCATE != 0);
                        end
                    end else if (hit_any) begin
                        douta_d = data_mem[hit_slot];
                        hit_d   = 1'b1;
                        hit_inc = 1'b1;
                    end else begin
                        ram_addr_d = bus.addra;
                        fetch_d    = 1'b1;
                        busy_d     = 1'b1;
                        miss_inc   = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.fetch_ack) begin
                    fill_en   = 1'b1;
                    fill_data = bus.ram_rdata;
                    douta_d   = bus.ram_rdata;
                    fetch_d   = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                if (bus.flush_ack) begin
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_inc && (hit_count_q != '1))
            hit_count_d = hit_count_q + STAT_WIDTH'(1);
        if (miss_inc && (miss_count_q != '1))
            miss_count_d = miss_count_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q      <= IDLE;
            douta_q      <= '0;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
            fetch_q      <= 1'b0;
            flush_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            douta_q      <= douta_d;
            hit_q        <= hit_d;
            busy_q       <= busy_d;
            fetch_q      <= fetch_d;
            flush_q      <= flush_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Valid bits and replacement pointers; a fill advances the pointer whether or not it chose the victim.
    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (inval_en) begin
            for (int s = 0; s < int'(SETS); s++)
                valid_q[s] <= '0;
        end else if (fill_en) begin
            valid_q[look_idx][victim_way] <= 1'b1;
            ptr_q[look_idx] <= (ptr_q[look_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                       : ptr_q[look_idx] + WAY_W'(1);
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            if (fill_en) begin
                data_mem[fill_slot]          <= fill_data;
                tag_q[look_idx][victim_way]  <= look_tag;
            end else if (wr_hit_en) begin
                data_mem[hit_slot] <= bus.dina;
            end
        end
    end

    assign bus.douta      = douta_q;
    assign bus.hit        = hit_q;
    assign bus.busy       = busy_q;
    assign bus.fetch      = fetch_q;
    assign bus.flush      = flush_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_set_assoc_cache_n_ways.sv
// Directed plus randomised bench for set_assoc_cache_n_ways against a per-set
// cache model and a flat main-memory array.
module tb_set_assoc_cache_n_ways;
    localparam int unsigned WORDS          = 1024;
    localparam int unsigned ADDR_WIDTH     = 12;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned WAYS           = 2;
    localparam int unsigned WRITE_ALLOCATE = 1;
    localparam int unsigned STAT_WIDTH     = 16;
    localparam int SETS     = int'(WORDS / WAYS);
    localparam int NWAYS    = int'(WAYS);
    localparam int STAT_MAX = (1 << STAT_WIDTH) - 1;
    localparam int RAM_SIZE = 1 << ADDR_WIDTH;

    logic clka = 1'b0;
    logic rsta = 1'b1;
    always #5 clka = ~clka;

    set_assoc_cache_n_ways_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .STAT_WIDTH(STAT_WIDTH)
    ) bus ();

    set_assoc_cache_n_ways #(
        .WORDS(WORDS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .WAYS(WAYS), .WRITE_ALLOCATE(WRITE_ALLOCATE), .STAT_WIDTH(STAT_WIDTH)
    ) dut (
        .clka(clka),
        .rsta(rsta),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: main memory plus the cache contents implied by the replacement rules.
    logic [31:0] ram_model [RAM_SIZE];
    bit          m_valid [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_ptr   [SETS];
    int          m_hits, m_miss;
    logic [31:0] m_douta;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= STAT_MAX) ? STAT_MAX : c + 1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_hits  = 0;
        m_miss  = 0;
        m_douta = '0;
    endtask

    function automatic int m_find(input int addr);
        for (int w = 0; w < NWAYS; w++)
            if (m_valid[addr % SETS][w] && m_tag[addr % SETS][w] == addr / SETS) return w;
        return -1;
    endfunction

    task automatic m_fill(input int addr, input logic [31:0] d);
        int s, v;
        s = addr % SETS;
        v = -1;
        for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) v = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % NWAYS;
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = addr / SETS;
        m_data[s][v]  = d;
    endtask

    task automatic drive_idle();
        bus.ena       = 1'b0;
        bus.wea       = 1'b0;
        bus.inval     = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.flush_ack = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"}, 64'(bus.hit_count), 64'(m_hits));
        check({tag, "_miss_count"}, 64'(bus.miss_count), 64'(m_miss));
    endtask

    // One stalled cycle: throw ignored requests, inval and the non-matching ack at the DUT.
    task automatic busy_cycle(input bit in_fetch, input int addr);
        @(negedge clka);
        bus.ena   = 1'($urandom_range(0, 1));
        bus.wea   = 1'($urandom_range(0, 1));
        bus.addra = ADDR_WIDTH'($urandom);
        bus.dina  = $urandom;
        bus.inval = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
        if (in_fetch) bus.flush_ack = 1'($urandom_range(0, 1));
        else          bus.fetch_ack = 1'($urandom_range(0, 1));
        @(posedge clka); #1;
        drive_idle();
        check("stall_busy", 64'(bus.busy), 64'(1));
        check("stall_hit", 64'(bus.hit), 64'(0));
        check("stall_fetch", 64'(bus.fetch), 64'(in_fetch));
        check("stall_flush", 64'(bus.flush), 64'(!in_fetch));
        check("stall_ram_addr", 64'(bus.ram_addr), 64'(addr));
        check("stall_douta", 64'(bus.douta), 64'(m_douta));
    endtask

    task automatic do_read(input int addr, input int nwait, output bit was_hit);
        int w;
        w = m_find(addr);
        @(negedge clka);
        bus.ena   = 1'b1;
        bus.wea   = 1'b0;
        bus.addra = ADDR_WIDTH'(addr);
        @(posedge clka); #1;
        drive_idle();
        was_hit = bus.hit;
        if (w >= 0) begin
            m_hits  = sat_inc(m_hits);
            m_douta = m_data[addr % SETS][w];
            check("rd_hit", 64'(bus.hit), 64'(1));
            check("rd_hit_douta", 64'(bus.douta), 64'(ram_model[addr]));
            check("rd_hit_busy", 64'(bus.busy), 64'(0));
        end else begin
            m_miss = sat_inc(m_miss);
            check("rd_miss_hit", 64'(bus.hit), 64'(0));
            check("rd_miss_fetch", 64'(bus.fetch), 64'(1));
            check("rd_miss_busy", 64'(bus.busy), 64'(1));
            check("rd_miss_ram_addr", 64'(bus.ram_addr), 64'(addr));
            check("rd_miss_douta_held", 64'(bus.douta), 64'(m_douta));
            repeat (nwait) busy_cycle(1'b1, addr);
            @(negedge clka);
            bus.fetch_ack = 1'b1;
            bus.ram_rdata = ram_model[addr];
            @(posedge clka); #1;
            drive_idle();
            bus.ram_rdata = $urandom;
            m_fill(addr, ram_model[addr]);
            m_douta = ram_model[addr];
            check("fill_fetch", 64'(bus.fetch), 64'(0));
            check("fill_busy", 64'(bus.busy), 64'(0));
            check("fill_hit", 64'(bus.hit), 64'(0));
            check("fill_douta", 64'(bus.douta), 64'(ram_model[addr]));
        end
        check_counts("rd");
    endtask

    task automatic do_write(input int addr, input logic [31:0] d, input int nwait, output bit was_hit);
        int w;
        w = m_find(addr);
        @(negedge clka);
        bus.ena   = 1'b1;
        bus.wea   = 1'b1;
        bus.addra = ADDR_WIDTH'(addr);
        bus.dina  = d;
        @(posedge clka); #1;
        drive_idle();
        bus.dina = $urandom;
        was_hit = bus.hit;
        if (w >= 0) begin
            m_hits = sat_inc(m_hits);
            m_data[addr % SETS][w] = d;
        end else begin
            m_miss = sat_inc(m_miss);
            if (WRITE_ALLOCATE != 0) m_fill(addr, d);
        end
        ram_model[addr] = d;
        check("wr_hit", 64'(bus.hit), 64'(w >= 0));
        check("wr_flush", 64'(bus.flush), 64'(1));
        check("wr_busy", 64'(bus.busy), 64'(1));
        check("wr_ram_addr", 64'(bus.ram_addr), 64'(addr));
        check("wr_ram_wdata", 64'(bus.ram_wdata), 64'(d));
        check("wr_douta_held", 64'(bus.douta), 64'(m_douta));
        check_counts("wr");
        repeat (nwait) busy_cycle(1'b0, addr);
        @(negedge clka);
        bus.flush_ack = 1'b1;
        @(posedge clka); #1;
        drive_idle();
        check("wr_done_flush", 64'(bus.flush), 64'(0));
        check("wr_done_busy", 64'(bus.busy), 64'(0));
        check("wr_done_hit", 64'(bus.hit), 64'(0));
    endtask

    // inval with a simultaneous request: the request must be dropped.
    task automatic do_inval();
        @(negedge clka);
        bus.inval = 1'b1;
        bus.ena   = 1'b1;
        bus.wea   = 1'($urandom_range(0, 1));
        bus.addra = ADDR_WIDTH'($urandom);
        @(posedge clka); #1;
        drive_idle();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
        check("inval_hit", 64'(bus.hit), 64'(0));
        check("inval_busy", 64'(bus.busy), 64'(0));
        check("inval_fetch", 64'(bus.fetch), 64'(0));
        check("inval_flush", 64'(bus.flush), 64'(0));
        check_counts("inval");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_douta"}, 64'(bus.douta), 64'(0));
        check({tag, "_hit"}, 64'(bus.hit), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_fetch"}, 64'(bus.fetch), 64'(0));
        check({tag, "_flush"}, 64'(bus.flush), 64'(0));
        check({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'(0));
        check({tag, "_ram_wdata"}, 64'(bus.ram_wdata), 64'(0));
        check({tag, "_hit_count"}, 64'(bus.hit_count), 64'(0));
        check({tag, "_miss_count"}, 64'(bus.miss_count), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clka);
        rsta = 1'b1;
        drive_idle();
        @(posedge clka); #1;
        rsta = 1'b0;
        m_reset();
        check_all_zero("reset");
    endtask

    initial begin
        bit h;
        int a, r, n_stream;
        drive_idle();
        bus.addra     = '0;
        bus.dina      = '0;
        bus.ram_rdata = '0;
        for (int i = 0; i < RAM_SIZE; i++) ram_model[i] = $urandom;
        m_reset();
        do_reset();

        // Write then read back the same word.
        do_write(0, 32'd2123000123, 10, h);
        check("t1_write_miss", 64'(h), 64'(0));
        do_read(0, 0, h);
        check("t1_read_hit", 64'(h), 64'(1));
        check("t1_douta", 64'(bus.douta), 64'(32'd2123000123));

        // Read miss, fill from RAM, re-read hits.
        ram_model[1000] = 32'd1002003009;
        do_read(1000, 2, h);
        check("t2_read_miss", 64'(h), 64'(0));
        check("t2_douta", 64'(bus.douta), 64'(32'd1002003009));
        do_read(1000, 0, h);
        check("t2_reread_hit", 64'(h), 64'(1));

        // Two tags share set 0 in two ways.
        do_write(512, 32'd998, 1, h);
        do_read(0, 0, h);
        check("t3_read0_hit", 64'(h), 64'(1));
        do_read(512, 0, h);
        check("t3_read512_hit", 64'(h), 64'(1));
        check("t3_douta", 64'(bus.douta), 64'(32'd998));

        // Third tag evicts the round-robin victim (the line holding address 0).
        do_write(1024, 32'd77, 0, h);
        do_read(512, 0, h);
        check("t4_read512_hit", 64'(h), 64'(1));
        do_read(0, 1, h);
        check("t4_read0_miss", 64'(h), 64'(0));

        // Random traffic over a few heavily contended sets.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            a = int'($urandom_range(0, 7)) * SETS + int'($urandom_range(0, 3));
            if (r < 45)      do_read(a, int'($urandom_range(0, 3)), h);
            else if (r < 93) do_write(a, $urandom, int'($urandom_range(0, 3)), h);
            else             do_inval();
        end

        // Reset in the middle of a fetch; a late ack must be ignored.
        @(negedge clka);
        bus.ena   = 1'b1;
        bus.wea   = 1'b0;
        bus.addra = ADDR_WIDTH'(3000);
        @(posedge clka); #1;
        drive_idle();
        check("t5_fetch", 64'(bus.fetch), 64'(1));
        check("t5_ram_addr", 64'(bus.ram_addr), 64'(3000));
        do_reset();
        @(negedge clka);
        bus.fetch_ack = 1'b1;
        bus.ram_rdata = 32'hDEAD_BEEF;
        @(posedge clka); #1;
        drive_idle();
        check_all_zero("t5_late_ack");
        do_read(1000, 1, h);
        check("t5_read1000_miss", 64'(h), 64'(0));

        // Invalidate-all, then saturate the hit counter with back-to-back hits.
        do_read(512, 0, h);
        do_inval();
        do_read(512, 0, h);
        check("t6_read512_miss", 64'(h), 64'(0));
        n_stream = STAT_MAX + 40;
        @(negedge clka);
        bus.ena   = 1'b1;
        bus.wea   = 1'b0;
        bus.addra = ADDR_WIDTH'(512);
        repeat (n_stream) @(posedge clka);
        #1;
        drive_idle();
        repeat (n_stream) m_hits = sat_inc(m_hits);
        check("t6_stream_hit", 64'(bus.hit), 64'(1));
        check("t6_stream_douta", 64'(bus.douta), 64'(ram_model[512]));
        check("t6_hit_count_model", 64'(bus.hit_count), 64'(m_hits));
        check("t6_hit_count_sat", 64'(bus.hit_count), 64'(65535));
        do_read(512, 0, h);
        check("t6_hit_after_sat", 64'(h), 64'(1));
        do_read(2000, 1, h);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
